// File: rtl/pc_stack_unit_if.sv
// Micro-op bus between the sequencer and the PC/return-stack unit.
// The sequencer (master) drives control and MBR data; the PC unit (slave) returns PC and stack status.
interface pc_stack_unit_if #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]       control_signal;
  logic [ADDR_W-1:0] from_MBR;
  logic [ADDR_W-1:0] to_MAR;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output control_signal, from_MBR,
    input  to_MAR, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
  );

  modport slave (
    input  control_signal, from_MBR,
    output to_MAR, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack: increment, jump, relative branch, call, return, hold.
// Stack misuse is reported by sticky overflow/underflow flags and never corrupts the stack.
module pc_stack_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                INC_BIT   = 6,
  parameter int                JMP_BIT   = 21,
  parameter int                REL_BIT   = 22,
  parameter int                CALL_BIT  = 23,
  parameter int                RET_BIT   = 24,
  parameter int                CLR_BIT   = 25
) (
  input logic               clk,
  input logic               rst_n,
  pc_stack_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              ovf_q;
  logic              unf_q;
  logic              ovf_set;
  logic              unf_set;
  logic              push;
  logic              full;
  logic              empty;
  logic              clr;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign clr      = bus.control_signal[CLR_BIT];
  assign push_idx = IDX_W'(count_q);
  assign top_idx  = IDX_W'(count_q - CNT_ONE);

  // Fixed priority INC > JMP > REL > CALL > RET; lower bits in the same cycle are ignored.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.control_signal[INC_BIT]) begin
      pc_d = pc_inc;
    end else if (bus.control_signal[JMP_BIT]) begin
      pc_d = bus.from_MBR;
    end else if (bus.control_signal[REL_BIT]) begin
      // Same-width add is the modulo-2^ADDR_W sum with a sign-extended offset.
      pc_d = pc_q + bus.from_MBR;
    end else if (bus.control_signal[CALL_BIT]) begin
      pc_d = bus.from_MBR;
      if (!full) begin
        push    = 1'b1;
        count_d = count_q + CNT_ONE;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.control_signal[RET_BIT]) begin
      if (!empty) begin
        pc_d    = stack_q[top_idx];
        count_d = count_q - CNT_ONE;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      if (push) begin
        stack_q[push_idx] <= pc_inc;
      end
      // A new event in the same cycle as CLR leaves the flag set.
      ovf_q <= ovf_set | (ovf_q & ~clr);
      unf_q <= unf_set | (unf_q & ~clr);
    end
  end

  assign bus.to_MAR    = pc_q;
  assign bus.ras_count = count_q;
  assign bus.ras_full  = full;
  assign bus.ras_empty = empty;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit (ADDR_W=8, RAS_DEPTH=4) against a queue-based reference model.
module tb_pc_stack_unit;

  localparam logic [31:0] C_INC  = 32'h1 << 6;
  localparam logic [31:0] C_JMP  = 32'h1 << 21;
  localparam logic [31:0] C_REL  = 32'h1 << 22;
  localparam logic [31:0] C_CALL = 32'h1 << 23;
  localparam logic [31:0] C_RET  = 32'h1 << 24;
  localparam logic [31:0] C_CLR  = 32'h1 << 25;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pc_stack_unit_if #(.ADDR_W(8), .RAS_DEPTH(DEPTH)) bus ();

  pc_stack_unit #(.ADDR_W(8), .RAS_DEPTH(DEPTH), .RESET_VEC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, stack as a queue (back = top).
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf;

  function automatic void model_reset();
    m_pc = 0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_step(input logic [31:0] cs, input logic [7:0] mbr);
    bit new_ovf = 0, new_unf = 0;
    int off;
    if (cs[6]) m_pc = (m_pc + 1) % 256;
    else if (cs[21]) m_pc = int'(mbr);
    else if (cs[22]) begin
      off  = (mbr >= 8'h80) ? int'(mbr) - 256 : int'(mbr);
      m_pc = (m_pc + off + 256) % 256;
    end else if (cs[23]) begin
      if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 256);
      else new_ovf = 1;
      m_pc = int'(mbr);
    end else if (cs[24]) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else new_unf = 1;
    end
    if (cs[25]) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (new_ovf) m_ovf = 1;
    if (new_unf) m_unf = 1;
  endfunction

  // Apply one micro-op for one edge and sample 1 ns after it.
  task automatic drive(input logic [31:0] cs, input logic [7:0] mbr);
    bus.control_signal = cs;
    bus.from_MBR = mbr;
    @(posedge clk);
    model_step(cs, mbr);
    #1;
    bus.control_signal = '0;
  endtask

  task automatic test_reset();
    bus.control_signal = '0;
    bus.from_MBR = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.to_MAR !== 8'h00 || bus.ras_count !== 3'd0 || bus.ras_empty !== 1'b1 ||
        bus.ras_full !== 1'b0 || bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h cnt=%0d e=%b f=%b o=%b u=%b, required pc=00 cnt=0 e=1 f=0 o=0 u=0",
               bus.to_MAR, bus.ras_count, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf);
    end
  endtask

  task automatic test_increment();
    logic [7:0] exp_seq [3] = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      drive(C_INC, 8'h00);
      n_checks++;
      if (bus.to_MAR !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL inc_%0d: pc=%h required %h", i, bus.to_MAR, exp_seq[i]);
      end
    end
    drive(C_JMP, 8'hFF);
    n_checks++;
    if (bus.to_MAR !== 8'hFF) begin
      n_fail++;
      $display("FAIL jmp_ff: pc=%h required ff", bus.to_MAR);
    end
    drive(C_INC, 8'h00);
    n_checks++;
    if (bus.to_MAR !== 8'h00) begin
      n_fail++;
      $display("FAIL inc_wrap: pc=%h required 00", bus.to_MAR);
    end
  endtask

  task automatic test_priority();
    drive(C_JMP, 8'h10);
    drive(C_INC | C_JMP, 8'h80);
    n_checks++;
    if (bus.to_MAR !== 8'h11) begin
      n_fail++;
      $display("FAIL prio_inc_jmp: pc=%h required 11", bus.to_MAR);
    end
    drive(C_JMP | C_CALL, 8'h80);
    n_checks++;
    if (bus.to_MAR !== 8'h80 || bus.ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL prio_jmp_call: pc=%h cnt=%0d required pc=80 cnt=0", bus.to_MAR, bus.ras_count);
    end
  endtask

  task automatic test_relative();
    drive(C_JMP, 8'h05);
    drive(C_REL, 8'hFD);
    n_checks++;
    if (bus.to_MAR !== 8'h02) begin
      n_fail++;
      $display("FAIL rel_neg: pc=%h required 02", bus.to_MAR);
    end
    drive(C_REL, 8'h7F);
    n_checks++;
    if (bus.to_MAR !== 8'h81) begin
      n_fail++;
      $display("FAIL rel_pos: pc=%h required 81", bus.to_MAR);
    end
    drive(C_REL, 8'h00);
    n_checks++;
    if (bus.to_MAR !== 8'h81) begin
      n_fail++;
      $display("FAIL rel_zero: pc=%h required 81", bus.to_MAR);
    end
  endtask

  task automatic test_nested_call();
    logic [31:0] ops   [4] = '{C_CALL, C_CALL, C_RET, C_RET};
    logic [7:0]  tgt   [4] = '{8'h40, 8'h60, 8'h00, 8'h00};
    logic [7:0]  exp_pc[4] = '{8'h40, 8'h60, 8'h41, 8'h21};
    logic [2:0]  exp_c [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    drive(C_JMP, 8'h20);
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], tgt[i]);
      n_checks++;
      if (bus.to_MAR !== exp_pc[i] || bus.ras_count !== exp_c[i]) begin
        n_fail++;
        $display("FAIL nested_%0d: pc=%h cnt=%0d required pc=%h cnt=%0d",
                 i, bus.to_MAR, bus.ras_count, exp_pc[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_overflow();
    // Pushed return addresses are PC+1 of each accepted call: 01, 11, 21, 31.
    logic [7:0] exp_ret[4] = '{8'h31, 8'h21, 8'h11, 8'h01};
    drive(C_JMP, 8'h00);
    for (int i = 1; i <= 5; i++) drive(C_CALL, 8'(i * 16));
    n_checks++;
    if (bus.to_MAR !== 8'h50 || bus.ras_count !== 3'd4 || bus.ras_full !== 1'b1 || bus.ras_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state: pc=%h cnt=%0d full=%b ovf=%b required pc=50 cnt=4 full=1 ovf=1",
               bus.to_MAR, bus.ras_count, bus.ras_full, bus.ras_ovf);
    end
    drive(C_CALL | C_CLR, 8'h55);
    n_checks++;
    if (bus.ras_ovf !== 1'b1 || bus.ras_count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b cnt=%0d required ovf=1 cnt=4", bus.ras_ovf, bus.ras_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(C_RET, 8'h00);
      n_checks++;
      if (bus.to_MAR !== exp_ret[i]) begin
        n_fail++;
        $display("FAIL ovf_ret_%0d: pc=%h required %h", i, bus.to_MAR, exp_ret[i]);
      end
    end
    drive(C_CLR, 8'h00);
    n_checks++;
    if (bus.ras_ovf !== 1'b0 || bus.ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b empty=%b required ovf=0 empty=1", bus.ras_ovf, bus.ras_empty);
    end
  endtask

  task automatic test_underflow_async_reset();
    drive(C_RET, 8'h00);
    n_checks++;
    if (bus.to_MAR !== 8'h01 || bus.ras_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_state: pc=%h unf=%b required pc=01 unf=1", bus.to_MAR, bus.ras_unf);
    end
    drive(C_RET | C_CLR, 8'h00);
    n_checks++;
    if (bus.ras_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_set_wins: unf=%b required 1", bus.ras_unf);
    end
    drive(C_CALL, 8'h77);
    drive(C_CALL, 8'h99);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.to_MAR !== 8'h00 || bus.ras_count !== 3'd0 || bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h cnt=%0d ovf=%b unf=%b required pc=00 cnt=0 ovf=0 unf=0",
               bus.to_MAR, bus.ras_count, bus.ras_ovf, bus.ras_unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(C_RET, 8'h00);
    n_checks++;
    if (bus.to_MAR !== 8'h00 || bus.ras_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discards_stack: pc=%h unf=%b required pc=00 unf=1", bus.to_MAR, bus.ras_unf);
    end
  endtask

  task automatic test_random();
    logic [31:0] cs;
    logic [7:0]  mbr;
    logic [31:0] used;
    used = C_INC | C_JMP | C_REL | C_CALL | C_RET | C_CLR;
    for (int i = 0; i < 400; i++) begin
      cs = $urandom & ~used;
      if ($urandom_range(0, 5) == 0) cs |= C_INC;
      if ($urandom_range(0, 5) == 0) cs |= C_JMP;
      if ($urandom_range(0, 5) == 0) cs |= C_REL;
      if ($urandom_range(0, 2) == 0) cs |= C_CALL;
      if ($urandom_range(0, 2) == 0) cs |= C_RET;
      if ($urandom_range(0, 7) == 0) cs |= C_CLR;
      mbr = 8'($urandom);
      drive(cs, mbr);
      n_checks++;
      if (bus.to_MAR !== 8'(m_pc) || bus.ras_count !== 3'(m_stack.size()) ||
          bus.ras_full !== (m_stack.size() == DEPTH) || bus.ras_empty !== (m_stack.size() == 0) ||
          bus.ras_ovf !== m_ovf || bus.ras_unf !== m_unf) begin
        n_fail++;
        $display("FAIL random_%0d: cs=%h mbr=%h pc=%h cnt=%0d f=%b e=%b o=%b u=%b, required pc=%h cnt=%0d o=%b u=%b",
                 i, cs, mbr, bus.to_MAR, bus.ras_count, bus.ras_full, bus.ras_empty, bus.ras_ovf,
                 bus.ras_unf, 8'(m_pc), m_stack.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_priority();
    test_relative();
    test_nested_call();
    test_overflow();
    test_underflow_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
